// File: rtl/clk_ratio_meter_if.sv
// Bundle of the meter's measured clock, start/done handshake and result bus.
interface clk_ratio_meter_if #(
  parameter int CNT_W = 16
);
  logic             meas_clk;
  logic             start;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             overflow;
  logic [CNT_W-1:0] total_cycles;
  logic [CNT_W-1:0] min_period;
  logic [CNT_W-1:0] max_period;
  logic [CNT_W-1:0] high_cycles;

  // Requester side: drives the clock under test and start.
  modport master (
    output meas_clk, start,
    input  busy, done, timeout, overflow,
    input  total_cycles, min_period, max_period, high_cycles
  );

  // Meter side.
  modport slave (
    input  meas_clk, start,
    output busy, done, timeout, overflow,
    output total_cycles, min_period, max_period, high_cycles
  );
endinterface

// File: rtl/clk_ratio_meter.sv
// Measures an asynchronous divided clock in units of clk: over WINDOW periods
// of meas_clk it reports summed period, min/max period and high time.
module clk_ratio_meter #(
  parameter int WINDOW  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  clk_ratio_meter_if.slave  mif
);

  localparam logic [7:0]       WIN_LAST = 8'(WINDOW - 1);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise, start_acc;
  logic [CNT_W-1:0] per_q, per_d;
  logic [7:0]       ecnt_q, ecnt_d;
  logic [CNT_W-1:0] tot_q, tot_d, min_q, min_d, max_q, max_d, hi_q, hi_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   tot_sum;
  logic             load_res, to_hit;
  logic [CNT_W-1:0] res_tot_q, res_min_q, res_max_q, res_hi_q;
  logic             to_q, ovf_res_q;

  // Every edge sees the same 2-3 cycle synchronizer delay, so rise-to-rise
  // distances are exact periods in clk units.
  assign rise      = s2_q & ~s3_q;
  assign start_acc = mif.start && (state_q == S_IDLE);

  // Synchronizer chain plus one extra stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= mif.meas_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Period counter: restarts at 1 on each rise (and on start), saturates.
  always_comb begin
    per_d = per_q;
    if (start_acc || rise) per_d = ONE;
    else if (!(&per_q))    per_d = per_q + ONE;
  end

  // Period counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) per_q <= '0;
    else     per_q <= per_d;
  end

  // State transitions; rise wins over timeout in the same cycle.
  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    to_hit   = 1'b0;
    case (state_q)
      S_IDLE: if (start_acc) state_d = S_ARM;
      S_ARM: begin
        if (rise) state_d = S_MEAS;
        else if (per_q >= TO_LIM) begin
          state_d = S_DONE;
          to_hit  = 1'b1;
        end
      end
      S_MEAS: begin
        if (rise && (ecnt_q == WIN_LAST)) begin
          state_d  = S_DONE;
          load_res = 1'b1;
        end else if (!rise && (per_q >= TO_LIM)) begin
          state_d = S_DONE;
          to_hit  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Accumulator next state: cleared on start, updated per rise / high sample.
  always_comb begin
    ecnt_d  = ecnt_q;
    tot_d   = tot_q;
    min_d   = min_q;
    max_d   = max_q;
    hi_d    = hi_q;
    ovf_d   = ovf_q;
    tot_sum = {1'b0, tot_q} + {1'b0, per_q};
    if (start_acc) begin
      ecnt_d = '0;
      tot_d  = '0;
      min_d  = '1;
      max_d  = '0;
      hi_d   = '0;
      ovf_d  = 1'b0;
    end else if (state_q == S_MEAS) begin
      if (rise) begin
        ecnt_d = ecnt_q + 8'd1;
        if (tot_sum[CNT_W]) begin
          tot_d = '1;
          ovf_d = 1'b1;
        end else begin
          tot_d = tot_sum[CNT_W-1:0];
        end
        if (per_q < min_q) min_d = per_q;
        if (per_q > max_q) max_d = per_q;
      end
      if (s2_q) begin
        if (&hi_q) ovf_d = 1'b1;
        else       hi_d  = hi_q + ONE;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecnt_q <= '0;
      tot_q  <= '0;
      min_q  <= '1;
      max_q  <= '0;
      hi_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ecnt_q <= ecnt_d;
      tot_q  <= tot_d;
      min_q  <= min_d;
      max_q  <= max_d;
      hi_q   <= hi_d;
      ovf_q  <= ovf_d;
    end
  end

  // Results load only on entry to DONE; the final rise is folded in via _d.
  // Flags clear on an accepted start and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_tot_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
      res_hi_q  <= '0;
      to_q      <= 1'b0;
      ovf_res_q <= 1'b0;
    end else begin
      if (start_acc) begin
        to_q      <= 1'b0;
        ovf_res_q <= 1'b0;
      end
      if (to_hit) begin
        res_tot_q <= '0;
        res_min_q <= '0;
        res_max_q <= '0;
        res_hi_q  <= '0;
        to_q      <= 1'b1;
        ovf_res_q <= ovf_d;
      end else if (load_res) begin
        res_tot_q <= tot_d;
        res_min_q <= min_d;
        res_max_q <= max_d;
        res_hi_q  <= hi_d;
        ovf_res_q <= ovf_d;
      end
    end
  end

  assign mif.busy         = (state_q == S_ARM) || (state_q == S_MEAS);
  assign mif.done         = (state_q == S_DONE);
  assign mif.timeout      = to_q;
  assign mif.overflow     = ovf_res_q;
  assign mif.total_cycles = res_tot_q;
  assign mif.min_period   = res_min_q;
  assign mif.max_period   = res_max_q;
  assign mif.high_cycles  = res_hi_q;

endmodule

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

- Measures an asynchronous divided clock against the system clock; the receiving end of the fractional clock dividers in this design.
- Over a programmable window it reports total clk cycles, minimum and maximum period, and high time of `meas_clk`.
- Used in place of free-running edge counters to check divider ratio and duty, e.g. 4.5 = alternating 4/5 periods.
- Start/done handshake; results held until the next measurement.

## Interface
- `WINDOW`, default 8: number of `meas_clk` periods per measurement (1..255).
- `CNT_W`, default 16: width of all result and period counters.
- `TIMEOUT`, default 1024: clk cycles without a `meas_clk` rising edge before the measurement aborts (must be < 2^CNT_W).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `meas_clk` in 1: clock under test, asynchronous; frequency ≤ clk/4, high and low phases ≥ 2 clk cycles each.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `busy` out 1: high in ARM and MEASURE.
- `done` out 1: one-cycle pulse when results (or timeout) are updated.
- `timeout` out 1: last measurement aborted; held until the next accepted `start`.
- `overflow` out 1: `total_cycles` or `high_cycles` saturated during the last measurement; held until the next accepted `start`.
- `total_cycles` out CNT_W: sum of WINDOW periods.
- `min_period` out CNT_W: shortest period in window.
- `max_period` out CNT_W: longest period in window.
- `high_cycles` out CNT_W: clk cycles with synchronized `meas_clk` high during the window.

## Operation
- **Synchronizer and edge detect**
  - `meas_clk` → s1 → s2 (2-FF synchronizer) → s3.
  - rise = s2 & ~s3.
  - Fixed 2–3 cycle latency, identical for every edge, so periods are exact in clk units.
- **Period counter `per_cnt`**
  - Loads 1 on a cycle with rise; otherwise increments, saturating at all-ones.
  - Loads 1 on accepted `start`.
  - Period captured at a rise = `per_cnt` value before the load.
  - Example: rises at t and t+P give period P.
- **FSM states:** IDLE, ARM, MEASURE, DONE.
  - IDLE: `start` → ARM. Clear `timeout`/`overflow`, edge count = 0, min accumulator = all-ones, max/total/high accumulators = 0.
  - ARM: waits for the first rise; that rise is a reference only and no period is recorded. rise → MEASURE.
  - MEASURE: each rise records a period:
    - total += P (saturating);
    - min = min(min, P);
    - max = max(max, P);
    - edge count += 1.
  - MEASURE: every cycle with s2 = 1 increments `high_cycles` (saturating).
  - MEASURE: the rise that brings edge count to WINDOW → DONE; its period and high sample are included.
  - ARM or MEASURE: `per_cnt` reaches TIMEOUT without a rise → DONE with `timeout` = 1. Result outputs are set to 0 on timeout.
  - DONE: lasts one cycle, then → IDLE. Result outputs are loaded from the accumulators on the transition into DONE.
- **Result outputs**
  - Change only on entry to DONE; otherwise hold.
  - `start` outside IDLE is ignored, including during DONE.
  - A rise coinciding with an accepted `start` is not used; ARM starts looking on the next cycle.
- **Saturation:** any accumulator saturation sets `overflow`, and the value stays all-ones.

## Timing
- **Reset:** all outputs 0; FSM IDLE; synchronizer flops 0. Reset mid-measurement discards everything, with no `done`.
- `busy` goes high the cycle after `start` is accepted.
- `done` = (state == DONE): high exactly one cycle, in the cycle after the final rise pulse (or the timeout cycle).
- `busy` is low in that same cycle.
- Results are valid from the `done` cycle onward.
- Earliest next `start` acceptance: the cycle after `done`.
- Measurement duration: first rise + WINDOW periods + 1 cycle.

## Test plan
- **Ideal /4:** `meas_clk` = clk/4 square wave, WINDOW = 8, start → `done` once with:
  - `total_cycles` = 32, `min_period` = `max_period` = 4, `high_cycles` = 16;
  - `timeout` = 0, `overflow` = 0.
- **Alternating 4/5 (ratio 4.5, high 2 cycles each), WINDOW = 8** → `total_cycles` = 36, `min_period` = 4, `max_period` = 5, `high_cycles` = 16.
- **Timeout:** `meas_clk` held low, TIMEOUT = 1024, start → `done` with `timeout` = 1 and results 0. Next start with /4 input → `timeout` clears and results match the ideal-/4 case.
- **Start handling:**
  - `start` pulsed during MEASURE → ignored; results identical to the undisturbed run, single `done`.
  - `start` coincident with a rise in IDLE → that edge is not counted.
- **Reset mid-MEASURE:** assert `rst` → all outputs 0, `busy` = 0 immediately, no `done`. A fresh start then measures correctly.
- **Overflow:** CNT_W = 6 (so saturation is at 63, below the 72-cycle window total), `meas_clk` = clk/9, WINDOW = 8 → `total_cycles` = 63 (saturated), `overflow` = 1, `min_period` = `max_period` = 9.
